// File: rtl/mux_4to1.sv
// Registered 4-to-1 operand multiplexer with load enable, echoed select and valid flag.
// Optional even-parity output out_par is built when MUX_4TO1_PARITY_EN is defined.
module mux_4to1 #(
    parameter int unsigned ANCHO = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       sel,
    input  logic [ANCHO-1:0] a,
    input  logic [ANCHO-1:0] b,
    input  logic [ANCHO-1:0] c,
    input  logic [ANCHO-1:0] d,
`ifdef MUX_4TO1_PARITY_EN
    output logic             out_par,
`endif
    output logic [ANCHO-1:0] out,
    output logic             out_valid,
    output logic [1:0]       sel_q
);

    logic [ANCHO-1:0] mux_d;

    // Unknown select codes in simulation fall back to operand a.
    always_comb begin
        mux_d = a;
        case (sel)
            2'd0:    mux_d = a;
            2'd1:    mux_d = b;
            2'd2:    mux_d = c;
            2'd3:    mux_d = d;
            default: mux_d = a;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
            sel_q     <= '0;
        end else if (en) begin
            out       <= mux_d;
            out_valid <= 1'b1;
            sel_q     <= sel;
        end else begin
            out_valid <= 1'b0;
        end
    end

`ifdef MUX_4TO1_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            out_par <= 1'b0;
        end else if (en) begin
            out_par <= ^mux_d;
        end
    end
`endif

endmodule

// File: tb/tb_mux_4to1.sv
// Directed self-checking bench for mux_4to1 (ANCHO=8); parity checks run when
// MUX_4TO1_PARITY_EN is defined for both bench and design.
module tb_mux_4to1;

    localparam int unsigned ANCHO = 8;

    logic             clk;
    logic             rst;
    logic             en;
    logic [1:0]       sel;
    logic [ANCHO-1:0] a, b, c, d;
    logic [ANCHO-1:0] out;
    logic             out_valid;
    logic [1:0]       sel_q;
`ifdef MUX_4TO1_PARITY_EN
    logic             out_par;
`endif

    int unsigned tests_run;
    int unsigned tests_failed;

    mux_4to1 #(.ANCHO(ANCHO)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sel       (sel),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
`ifdef MUX_4TO1_PARITY_EN
        .out_par   (out_par),
`endif
        .out       (out),
        .out_valid (out_valid),
        .sel_q     (sel_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just past it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [ANCHO-1:0] ops [4];

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b1; en = 1'b1; sel = 2'd0;
        a = 8'h24; b = 8'h00; c = 8'h00; d = 8'h00;

        // Reset held two cycles with en=1 and a live operand
        step();
        step();
        check("rst_out",   64'(out),       64'h00);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_selq",  64'(sel_q),     64'd0);
`ifdef MUX_4TO1_PARITY_EN
        check("rst_par",   64'(out_par),   64'd0);
`endif
        rst = 1'b0;
        step();
        check("first_load_out",   64'(out),       64'h24);
        check("first_load_valid", 64'(out_valid), 64'd1);

        // Select sweep
        a = 8'h24; b = 8'h81; c = 8'h09; d = 8'h63;
        ops[0] = 8'h24; ops[1] = 8'h81; ops[2] = 8'h09; ops[3] = 8'h63;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            step();
            check($sformatf("sweep_out%0d", s),   64'(out),       64'(ops[s]));
            check($sformatf("sweep_selq%0d", s),  64'(sel_q),     64'(s));
            check($sformatf("sweep_valid%0d", s), 64'(out_valid), 64'd1);
        end

        // Hold with en=0 while operands and select change
        sel = 2'd2;
        step();
        check("hold_load_out", 64'(out), 64'h09);
        en = 1'b0; c = 8'hFF; sel = 2'd3;
        step();
        check("hold_out",   64'(out),       64'h09);
        check("hold_selq",  64'(sel_q),     64'd2);
        check("hold_valid", 64'(out_valid), 64'd0);
        step();
        check("hold2_out",  64'(out),       64'h09);
        check("hold2_selq", 64'(sel_q),     64'd2);

        // Random operand sets, each swept over all selects
        en = 1'b1;
        for (int n = 0; n < 14; n++) begin
            ops[0] = 8'($urandom); ops[1] = 8'($urandom);
            ops[2] = 8'($urandom); ops[3] = 8'($urandom);
            a = ops[0]; b = ops[1]; c = ops[2]; d = ops[3];
            for (int s = 0; s < 4; s++) begin
                sel = 2'(s);
                step();
                check($sformatf("rnd%0d_out%0d", n, s), 64'(out), 64'(ops[s]));
                check($sformatf("rnd%0d_selq%0d", n, s), 64'(sel_q), 64'(s));
                check($sformatf("rnd%0d_valid%0d", n, s), 64'(out_valid), 64'd1);
            end
        end

        // Reset priority mid-stream
        a = 8'h24; b = 8'h81; c = 8'h09; d = 8'h63;
        sel = 2'd3;
        step();
        check("pre_rst_out", 64'(out), 64'h63);
        rst = 1'b1; sel = 2'd1;
        step();
        check("prio_out",   64'(out),       64'h00);
        check("prio_valid", 64'(out_valid), 64'd0);
        check("prio_selq",  64'(sel_q),     64'd0);
        rst = 1'b0;
        step();
        check("post_rst_out",   64'(out),       64'h81);
        check("post_rst_selq",  64'(sel_q),     64'd1);
        check("post_rst_valid", 64'(out_valid), 64'd1);

`ifdef MUX_4TO1_PARITY_EN
        check("par_b81", 64'(out_par), 64'd0);
        sel = 2'd3;
        step();
        check("par_d63", 64'(out_par), 64'd0);
        a = 8'h07; sel = 2'd0;
        step();
        check("par_a07", 64'(out_par), 64'd1);
        en = 1'b0; sel = 2'd1;
        step();
        check("par_hold", 64'(out_par), 64'd1);
        en = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
